vga_timing: RTL and testbench

//   Raster timing generator driving the pixel-coordinate interface consumed by the block/stripe

---
 rtl/vga_timing_if.sv | 13 +
 rtl/vga_timing.sv | 86 ++++++++
 tb/tb_vga_timing.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Pixel-coordinate and sync bundle from the raster timing generator to the
// pixel generators and the VGA connector.
interface vga_timing_if;
  logic [9:0] col;
  logic [9:0] row;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (output col, row, valid, hsync, vsync, frame_start);
  modport slave  (input  col, row, valid, hsync, vsync, frame_start);
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters with every output decoded
// from the current count and registered, so outputs trail the counters by one clk.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_if.master  vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // All compares are 10-bit unsigned; larger timings would silently alias.
  if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_params
    $error("vga_timing: H_TOTAL/V_TOTAL must be below 1024");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [9:0] col_q, col_d, row_q, row_d;
  logic       valid_q, valid_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
  end

  // Output decode works on the pre-advance count, giving the one-clk lag.
  always_comb begin
    col_d         = hcount_q;
    row_d         = vcount_q;
    valid_d       = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    hsync_d       = !((hcount_q >= HS_START) && (hcount_q < HS_END));
    vsync_d       = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    frame_start_d = (hcount_q == '0) && (vcount_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      col_q         <= '0;
      row_q         <= '0;
      valid_q       <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      col_q         <= col_d;
      row_q         <= row_d;
      valid_q       <= valid_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.col         = col_q;
  assign vga.row         = row_q;
  assign vga.valid       = valid_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: dut_a at default 640x480 timing for line-level checks,
// dut_b with a shrunken raster so whole frames fit in a short run.
module tb_vga_timing;
  localparam int BHV = 16, BHF = 2, BHS = 4, BHB = 2;   // 24 clks per line
  localparam int BVV = 8,  BVF = 1, BVS = 2, BVB = 2;   // 13 lines per frame
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_timing_if a_if ();
  vga_timing_if b_if ();

  vga_timing dut_a (.clk(clk), .reset(reset), .vga(a_if.master));
  vga_timing #(.H_VISIBLE(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
               .V_VISIBLE(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB))
    dut_b (.clk(clk), .reset(reset), .vga(b_if.master));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {valid, hsync, vsync, frame_start} for a counter position
  function automatic logic [3:0] decode(int h, int v, int hv, int hf, int hs,
                                        int vv, int vf, int vs);
    logic val, hsn, vsn, fs;
    val = (h < hv) && (v < vv);
    hsn = !(h >= hv + hf && h < hv + hf + hs);
    vsn = !(v >= vv + vf && v < vv + vf + vs);
    fs  = (h == 0) && (v == 0);
    return {val, hsn, vsn, fs};
  endfunction

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({a_if.col, a_if.row} !== 20'd0 ||
        {a_if.valid, a_if.hsync, a_if.vsync, a_if.frame_start} !== 4'b0110) begin
      bad++;
      $display("FAIL reset_a col=%0d row=%0d vhvf=%b want 0 0 0110", a_if.col, a_if.row,
               {a_if.valid, a_if.hsync, a_if.vsync, a_if.frame_start});
    end
    total++;
    if ({b_if.col, b_if.row} !== 20'd0 ||
        {b_if.valid, b_if.hsync, b_if.vsync, b_if.frame_start} !== 4'b0110) begin
      bad++;
      $display("FAIL reset_b col=%0d row=%0d vhvf=%b want 0 0 0110", b_if.col, b_if.row,
               {b_if.valid, b_if.hsync, b_if.vsync, b_if.frame_start});
    end
    reset = 1'b0;
    tick();
    total++;
    if ({a_if.col, a_if.row} !== 20'd0 ||
        {a_if.valid, a_if.hsync, a_if.vsync, a_if.frame_start} !== 4'b1111) begin
      bad++;
      $display("FAIL first_out col=%0d row=%0d vhvf=%b want 0 0 1111", a_if.col, a_if.row,
               {a_if.valid, a_if.hsync, a_if.vsync, a_if.frame_start});
    end
  endtask

  // Continues from the first post-reset sample of dut_a (col 0, row 0).
  task automatic test_line();
    int vcnt = 0, hcnt = 0, hfirst = -1, colerr = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick();
      if (a_if.col !== 10'(i) || a_if.row !== 10'd0) colerr++;
      if (a_if.valid === 1'b1) vcnt++;
      if (a_if.hsync === 1'b0) begin
        hcnt++;
        if (hfirst < 0) hfirst = int'(a_if.col);
      end
    end
    total++;
    if (colerr != 0) begin bad++; $display("FAIL line_col_seq errors=%0d want 0", colerr); end
    total++;
    if (vcnt != 640) begin bad++; $display("FAIL line_valid_cnt got=%0d want 640", vcnt); end
    total++;
    if (hcnt != 96) begin bad++; $display("FAIL line_hsync_cnt got=%0d want 96", hcnt); end
    total++;
    if (hfirst != 656) begin bad++; $display("FAIL line_hsync_start got=%0d want 656", hfirst); end
    tick();
    total++;
    if (a_if.col !== 10'd0 || a_if.row !== 10'd1) begin
      bad++;
      $display("FAIL line_wrap col=%0d row=%0d want 0 1", a_if.col, a_if.row);
    end
  endtask

  task automatic test_frame();
    int fs_cnt = 0, vs_cnt = 0, vs_bad = 0, val_bad = 0;
    bit last_seen = 0;
    int c, r;
    restart();
    for (int i = 0; i < BHT * BVT; i++) begin
      if (i > 0) tick();
      c = int'(b_if.col);
      r = int'(b_if.row);
      if (b_if.frame_start === 1'b1) fs_cnt++;
      if (b_if.vsync !== 1'b1) begin
        vs_cnt++;
        if (r < BVV + BVF || r >= BVV + BVF + BVS) vs_bad++;
      end
      if (r >= BVV && b_if.valid !== 1'b0) val_bad++;
      if (c == BHV - 1 && r == BVV - 1) begin
        total++;
        if (b_if.valid !== 1'b1) begin bad++; $display("FAIL bnd_last_vis valid=%b want 1", b_if.valid); end
      end
      if (c == BHV && r == BVV - 1) begin
        total++;
        if (b_if.valid !== 1'b0) begin bad++; $display("FAIL bnd_h_blank valid=%b want 0", b_if.valid); end
      end
      if (c == 0 && r == BVV) begin
        total++;
        if (b_if.valid !== 1'b0) begin bad++; $display("FAIL bnd_v_blank valid=%b want 0", b_if.valid); end
      end
      if (c == BHT - 1 && r == BVT - 1) last_seen = 1;
    end
    total++;
    if (fs_cnt != 1) begin bad++; $display("FAIL frame_start_cnt got=%0d want 1", fs_cnt); end
    total++;
    if (vs_cnt != BHT * BVS) begin bad++; $display("FAIL vsync_cnt got=%0d want %0d", vs_cnt, BHT * BVS); end
    total++;
    if (vs_bad != 0) begin bad++; $display("FAIL vsync_rows stray=%0d want 0", vs_bad); end
    total++;
    if (val_bad != 0) begin bad++; $display("FAIL valid_vblank stray=%0d want 0", val_bad); end
    total++;
    if (!last_seen) begin bad++; $display("FAIL frame_last_pos seen=0 want 1"); end
    tick();
    total++;
    if (b_if.col !== 10'd0 || b_if.row !== 10'd0 || b_if.frame_start !== 1'b1) begin
      bad++;
      $display("FAIL frame_wrap col=%0d row=%0d fs=%b want 0 0 1", b_if.col, b_if.row, b_if.frame_start);
    end
  endtask

  task automatic test_mid_reset();
    restart();
    repeat ((BVV + BVF) * BHT + 20) tick();
    total++;
    if (b_if.col !== 10'd20 || b_if.row !== 10'(BVV + BVF) || b_if.hsync !== 1'b0 || b_if.vsync !== 1'b0) begin
      bad++;
      $display("FAIL mid_pos col=%0d row=%0d hs=%b vs=%b want 20 %0d 0 0",
               b_if.col, b_if.row, b_if.hsync, b_if.vsync, BVV + BVF);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({b_if.valid, b_if.hsync, b_if.vsync, b_if.frame_start} !== 4'b0110 || b_if.col !== 10'd0) begin
      bad++;
      $display("FAIL mid_reset vhvf=%b col=%0d want 0110 0",
               {b_if.valid, b_if.hsync, b_if.vsync, b_if.frame_start}, b_if.col);
    end
    reset = 1'b0;
    tick();
    total++;
    if (b_if.col !== 10'd0 || b_if.row !== 10'd0 || b_if.frame_start !== 1'b1) begin
      bad++;
      $display("FAIL mid_restart col=%0d row=%0d fs=%b want 0 0 1", b_if.col, b_if.row, b_if.frame_start);
    end
  endtask

  task automatic test_scoreboard();
    int ah = 0, av = 0, bh = 0, bv = 0, aerr = 0, berr = 0, xerr = 0;
    logic [3:0] ea, eb;
    restart();
    for (int i = 0; i < 1700; i++) begin
      if (i > 0) tick();
      ea = decode(ah, av, 640, 16, 96, 480, 10, 2);
      eb = decode(bh, bv, BHV, BHF, BHS, BVV, BVF, BVS);
      if (a_if.col !== 10'(ah) || a_if.row !== 10'(av) ||
          {a_if.valid, a_if.hsync, a_if.vsync, a_if.frame_start} !== ea) aerr++;
      if (b_if.col !== 10'(bh) || b_if.row !== 10'(bv) ||
          {b_if.valid, b_if.hsync, b_if.vsync, b_if.frame_start} !== eb) berr++;
      if ($isunknown({a_if.col, a_if.row, a_if.valid, a_if.hsync, a_if.vsync, a_if.frame_start,
                      b_if.col, b_if.row, b_if.valid, b_if.hsync, b_if.vsync, b_if.frame_start})) xerr++;
      ah++;
      if (ah == 800) begin ah = 0; av = (av == 524) ? 0 : av + 1; end
      bh++;
      if (bh == BHT) begin bh = 0; bv = (bv == BVT - 1) ? 0 : bv + 1; end
    end
    total++;
    if (aerr != 0) begin bad++; $display("FAIL sb_default errors=%0d want 0", aerr); end
    total++;
    if (berr != 0) begin bad++; $display("FAIL sb_small errors=%0d want 0", berr); end
    total++;
    if (xerr != 0) begin bad++; $display("FAIL sb_unknown cycles=%0d want 0", xerr); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
